mips_bus_mem_responder: RTL and testbench

Synthesizable memory-mapped responder for the `mips_cpu_bus` interface: the slave end of the CPU's read/write/waitrequest bus. It holds a byte-addressed RAM image and services single-word reads and byte-enabled writes. Each access is stretched by a parameterized number of `waitrequest` cycles, so CPU stall handling can be exercised in synthesizable form. It replaces ad-hoc behavioural delay models in system-level benches and FPGA builds.

---
 rtl/mips_bus_pkg.sv | 22 ++
 rtl/mips_bus_mem_array.sv | 40 ++++
 rtl/mips_bus_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_mips_bus_mem_responder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types for the mips_cpu_bus memory responder.
// Optional build macro used by the top level: MEM_RESP_CHECK_EN.
package mips_bus_pkg;

    // Responder handshake state: idle, or counting down waitrequest cycles.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } resp_state_t;

    // Wait-cycle counter, wide enough for latencies 0..15.
    typedef logic [3:0] lat_t;

    // Byte lanes per 32-bit bus word.
    localparam int BYTE_LANES = 4;

    // Convert an integer latency parameter into the counter type.
    function automatic lat_t to_lat(input int unsigned l);
        return lat_t'(l);
    endfunction

endpackage

// File: rtl/mips_bus_mem_array.sv
// Word-organised RAM with per-byte-lane write enables.
// Asynchronous (combinational) word read, synchronous byte-enabled write.
module mips_bus_mem_array
    import mips_bus_pkg::*;
#(
    parameter string RAM_INIT_FILE = "",
    parameter int    ADDR_WIDTH    = 13
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-3:0] word_addr,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int WORDS = 1 << (ADDR_WIDTH - 2);

    logic [31:0] mem [WORDS];

    // Power-up contents: zeros.
    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = '0;
        end
    end

    // Byte-enabled write; lane i carries wdata[8i+7:8i] to byte base+i.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (we && be[i]) begin
                mem[word_addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Asynchronous word read.
    assign rdata = mem[word_addr];

endmodule

// File: rtl/mips_bus_mem_responder.sv
// Slave end of the mips_cpu_bus read/write/waitrequest interface.
// Each access is stretched by READ_LATENCY or WRITE_LATENCY waitrequest
// cycles, then completes in the cycle where waitrequest is low.
// Handshake: a transfer completes in the cycle where (read|write) is high
// and waitrequest is low; the master holds its request until then.
// Optional build macro MEM_RESP_CHECK_EN adds a sticky protocol error
// output err and simulation $error reports.
// fsm_state exposes the handshake state (0 = IDLE, 1 = WAIT).
module mips_bus_mem_responder
    import mips_bus_pkg::*;
#(
    parameter string RAM_INIT_FILE = "",
    parameter int    ADDR_WIDTH    = 13,
    parameter int    READ_LATENCY  = 2,
    parameter int    WRITE_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic [31:0] writedata,
    output logic        waitrequest,
    output logic [31:0] readdata,
`ifdef MEM_RESP_CHECK_EN
    output logic        err,
`endif
    output logic        fsm_state
);

    if (READ_LATENCY < 0 || READ_LATENCY > 15) begin : g_bad_rd_lat
        $error("READ_LATENCY must be in 0..15");
    end
    if (WRITE_LATENCY < 0 || WRITE_LATENCY > 15) begin : g_bad_wr_lat
        $error("WRITE_LATENCY must be in 0..15");
    end

    localparam lat_t RD_LAT = to_lat(READ_LATENCY);
    localparam lat_t WR_LAT = to_lat(WRITE_LATENCY);

    resp_state_t           state;
    resp_state_t           state_next;
    lat_t                  cnt;
    lat_t                  cnt_next;
    lat_t                  lat;
    logic                  req;
    logic                  done;
    logic                  mem_we;
    logic [31:0]           mem_rdata;
    logic [ADDR_WIDTH-3:0] word_addr;
    logic                  unused_addr_bits;

    // A simultaneous read+write is a write, so it takes the write latency.
    assign req       = read | write;
    assign lat       = write ? WR_LAT : RD_LAT;
    assign word_addr = address[ADDR_WIDTH-1:2];

    // Upper bits alias away and the low two bits select nothing.
    assign unused_addr_bits = ^{address[31:ADDR_WIDTH], address[1:0]};

    // State and wait counter; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, waitrequest and completion strobe.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        waitrequest = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (lat == '0) begin
                        done = 1'b1;
                    end else begin
                        waitrequest = 1'b1;
                        cnt_next    = lat - lat_t'(1);
                        state_next  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    // Master abandoned the request: drop it silently.
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt != '0) begin
                    waitrequest = 1'b1;
                    cnt_next    = cnt - lat_t'(1);
                end else begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Write commits on the edge closing the completion cycle.
    assign mem_we    = done & write;
    // Read data only in a pure-read completion cycle, zero otherwise.
    assign readdata  = (done & read & ~write) ? mem_rdata : '0;
    assign fsm_state = (state == WAIT);

    mips_bus_mem_array #(
        .RAM_INIT_FILE (RAM_INIT_FILE),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_mem (
        .clk       (clk),
        .word_addr (word_addr),
        .we        (mem_we),
        .be        (byteenable),
        .wdata     (writedata),
        .rdata     (mem_rdata)
    );

`ifdef MEM_RESP_CHECK_EN
    logic [31:0] prev_address;
    logic        prev_read;
    logic        prev_write;
    logic        err_evt;
    logic        err_q;

    // Last-cycle request snapshot, used to spot changes mid-transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_address <= '0;
            prev_read    <= 1'b0;
            prev_write   <= 1'b0;
        end else begin
            prev_address <= address;
            prev_read    <= read;
            prev_write   <= write;
        end
    end

    // Protocol violations seen this cycle.
    always_comb begin
        err_evt = 1'b0;
        if (req && (address[1:0] != 2'b00)) err_evt = 1'b1;
        if (read && write)                  err_evt = 1'b1;
        if (write && (byteenable == 4'b0))  err_evt = 1'b1;
        if ((state == WAIT) &&
            ((address != prev_address) || (read != prev_read) || (write != prev_write)))
            err_evt = 1'b1;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (err_evt) begin
            err_q <= 1'b1;
        end
    end

    // Simulation report of each violation.
    always_ff @(posedge clk) begin
        if (reset && err_evt) begin
            $error("mips_bus_mem_responder: protocol violation at address %h", address);
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_mips_bus_mem_responder.sv
// Bench for mips_bus_mem_responder: table-driven vectors, hand-written
// multi-cycle sequences, then randomized traffic against a byte-array model.
// A second instance built with zero latency covers the same-cycle path.
module tb_mips_bus_mem_responder;

  localparam int AW      = 13;
  localparam int RL      = 2;
  localparam int WL      = 3;
  localparam int MAX_WAIT = 40;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;

  logic        read, write;
  logic [31:0] address, writedata, readdata;
  logic [3:0]  byteenable;
  logic        waitrequest, fsm_state;

  logic        z_read, z_write;
  logic [31:0] z_address, z_writedata, z_readdata;
  logic [3:0]  z_byteenable;
  logic        z_waitrequest, z_fsm_state;
`ifdef MEM_RESP_CHECK_EN
  logic        err, z_err;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired: got=running required=finished");
    $fatal(1, "watchdog");
  end

  mips_bus_mem_responder #(
    .RAM_INIT_FILE (""),
    .ADDR_WIDTH    (AW),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .read        (read),
    .write       (write),
    .address     (address),
    .byteenable  (byteenable),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata),
`ifdef MEM_RESP_CHECK_EN
    .err         (err),
`endif
    .fsm_state   (fsm_state)
  );

  mips_bus_mem_responder #(
    .RAM_INIT_FILE (""),
    .ADDR_WIDTH    (8),
    .READ_LATENCY  (0),
    .WRITE_LATENCY (0)
  ) dut_z (
    .clk         (clk),
    .reset       (reset),
    .read        (z_read),
    .write       (z_write),
    .address     (z_address),
    .byteenable  (z_byteenable),
    .writedata   (z_writedata),
    .waitrequest (z_waitrequest),
    .readdata    (z_readdata),
`ifdef MEM_RESP_CHECK_EN
    .err         (z_err),
`endif
    .fsm_state   (z_fsm_state)
  );

  // ---------------- scoreboard ----------------
  int checks;
  int failures;
  logic [31:0] exp_q[$];
  logic [7:0]  model_mem [0:(1<<AW)-1];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h required=%h", name, got, exp);
    end
  endtask

  // Byte-addressed model: alias modulo capacity, then align down to a word.
  function automatic int unsigned word_base(input logic [31:0] a);
    return ((a % (32'd1 << AW)) / 4) * 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned b;
    b = word_base(a);
    return {model_mem[b+3], model_mem[b+2], model_mem[b+1], model_mem[b]};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    int unsigned b;
    b = word_base(a);
    for (int i = 0; i < 4; i++)
      if (be[i]) model_mem[b+i] = d[8*i +: 8];
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the edge that
  // closes the completion cycle with the request dropped.
  task automatic xfer(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d,
                      output logic [31:0] rdata, output int waits);
    bit done;
    bit leak;
    done  = 1'b0;
    leak  = 1'b0;
    waits = 0;
    rdata = '0;
    address = a; byteenable = b; writedata = d; read = rd; write = wr;
    for (int n = 0; n < MAX_WAIT && !done; n++) begin
      @(negedge clk);
      if (waitrequest) begin
        waits++;
        if (readdata !== 32'h0) leak = 1'b1;
      end else begin
        done  = 1'b1;
        rdata = readdata;
      end
    end
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    check("xfer_completed", {31'b0, done}, 32'd1);
    check("readdata_zero_while_waiting", {31'b0, leak}, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    int          exp_waits;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  logic [31:0] rdata;
  int          waits;
  logic [5:0]  pat;
  logic [5:0]  exp_pat;

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = 8'h00;

    vecs[0] = '{0, 1, 32'h0000_0000, 4'hF, 32'h8C02_0004, WL, 32'h0};
    vecs[1] = '{1, 0, 32'h0000_0000, 4'h0, 32'h0,         RL, 32'h8C02_0004};
    vecs[2] = '{0, 1, 32'h0000_0010, 4'hF, 32'h0,         WL, 32'h0};
    vecs[3] = '{0, 1, 32'h0000_0010, 4'b0101, 32'hAABB_CCDD, WL, 32'h0};
    vecs[4] = '{1, 0, 32'h0000_0010, 4'h0, 32'h0,         RL, 32'h00BB_00DD};
    vecs[5] = '{1, 0, 32'h0000_2010, 4'h0, 32'h0,         RL, 32'h00BB_00DD};
    vecs[6] = '{0, 1, 32'h0000_1FFC, 4'b1000, 32'h1234_5678, WL, 32'h0};
    vecs[7] = '{1, 0, 32'hFFFF_FFFC, 4'h0, 32'h0,         RL, 32'h1200_0000};
    vecs[8] = '{1, 1, 32'h0000_0040, 4'hF, 32'hCAFE_F00D, WL, 32'h0};
    vecs[9] = '{1, 0, 32'h0000_0040, 4'h0, 32'h0,         RL, 32'hCAFE_F00D};

    // Reset with the bus idle.
    reset = 1'b0;
    read = 0; write = 0; address = '0; byteenable = '0; writedata = '0;
    z_read = 0; z_write = 0; z_address = '0; z_byteenable = '0; z_writedata = '0;
    repeat (3) @(negedge clk);
    check("reset_waitrequest", {31'b0, waitrequest}, 32'd0);
    check("reset_readdata", readdata, 32'h0);
    check("reset_state", {31'b0, fsm_state}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(1);

    // Table-driven transfers.
    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].data, rdata, waits);
      check($sformatf("vec%0d_waits", i), waits, vecs[i].exp_waits);
      check($sformatf("vec%0d_readdata", i), rdata, vecs[i].exp_rdata);
      if (vecs[i].wr) model_write(vecs[i].addr, vecs[i].be, vecs[i].data);
    end

    // Back-to-back: read held across two transfers, each with a full wait.
    exp_pat = 6'b011011;
    address = 32'h0; read = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pat[k] = waitrequest;
      if (!waitrequest) check("b2b_readdata", readdata, 32'h8C02_0004);
    end
    @(posedge clk); #1;
    read = 1'b0;
    check("b2b_waitrequest_pattern", {26'b0, pat}, {26'b0, exp_pat});

    // Write dropped after one wait cycle: nothing committed.
    address = 32'h20; writedata = 32'hFFFF_FFFF; byteenable = 4'hF; write = 1'b1;
    @(negedge clk);
    check("drop_first_cycle_wait", {31'b0, waitrequest}, 32'd1);
    @(posedge clk); #1;
    write = 1'b0;
    @(negedge clk);
    check("drop_waitrequest_low", {31'b0, waitrequest}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("drop_back_to_idle", {31'b0, fsm_state}, 32'd0);
    @(posedge clk); #1;
    xfer(1, 0, 32'h20, 4'h0, 32'h0, rdata, waits);
    check("drop_no_write", rdata, model_read(32'h20));

    // Reset pulsed mid-read.
    address = 32'h0; read = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0; read = 1'b0;
    #1;
    check("rst_read_waitrequest", {31'b0, waitrequest}, 32'd0);
    check("rst_read_state", {31'b0, fsm_state}, 32'd0);
    check("rst_read_readdata", readdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(1);

    // Reset during a write's completion cycle: write aborted.
    address = 32'h30; writedata = 32'h5A5A_5A5A; byteenable = 4'hF; write = 1'b1;
    idle_cycles(WL);
    @(negedge clk);
    check("rst_write_completion_cycle", {31'b0, waitrequest}, 32'd0);
    #1 reset = 1'b0;
    #1;
    check("rst_write_state", {31'b0, fsm_state}, 32'd0);
    write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(1);
    xfer(1, 0, 32'h30, 4'h0, 32'h0, rdata, waits);
    check("rst_write_not_committed", rdata, model_read(32'h30));
    xfer(1, 0, 32'h10, 4'h0, 32'h0, rdata, waits);
    check("ram_survives_reset", rdata, 32'h00BB_00DD);

    // Zero-latency instance: completes in the request cycle.
    z_address = 32'h104; z_writedata = 32'h1357_2468; z_byteenable = 4'hF; z_write = 1'b1;
    @(negedge clk);
    check("zlat_write_no_wait", {31'b0, z_waitrequest}, 32'd0);
    check("zlat_write_readdata", z_readdata, 32'h0);
    @(posedge clk); #1;
    z_write = 1'b0; z_address = 32'h4; z_read = 1'b1;
    @(negedge clk);
    check("zlat_read_no_wait", {31'b0, z_waitrequest}, 32'd0);
    check("zlat_read_data", z_readdata, 32'h1357_2468);
    check("zlat_state", {31'b0, z_fsm_state}, 32'd0);
    @(posedge clk); #1;
    z_read = 1'b0;

    // Randomized traffic against the byte model.
    for (int t = 0; t < 150; t++) begin
      bit          is_wr;
      logic [31:0] a, d;
      logic [3:0]  b;
      is_wr = 1'($urandom_range(0, 1));
      a     = $urandom & 32'hFFFF_FFFC;
      b     = 4'($urandom_range(1, 15));
      d     = $urandom;
      if (is_wr) begin
        xfer(0, 1, a, b, d, rdata, waits);
        check("rand_write_waits", waits, WL);
        check("rand_write_readdata", rdata, 32'h0);
        model_write(a, b, d);
      end else begin
        exp_q.push_back(model_read(a));
        xfer(1, 0, a, 4'h0, 32'h0, rdata, waits);
        check("rand_read_waits", waits, RL);
        check("rand_read_data", rdata, exp_q.pop_front());
      end
      if ($urandom_range(0, 3) == 0) idle_cycles(1);
    end

`ifdef MEM_RESP_CHECK_EN
    // Misaligned read flags a sticky error cleared only by reset.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("err_after_reset", {31'b0, err}, 32'd0);
    @(posedge clk); #1;
    xfer(1, 0, 32'h3, 4'h0, 32'h0, rdata, waits);
    idle_cycles(3);
    @(negedge clk);
    check("err_sticky", {31'b0, err}, 32'd1);
    reset = 1'b0;
    #1;
    check("err_cleared_by_reset", {31'b0, err}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
`endif

    idle_cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
